mem_port_arbiter: RTL

- Shares the single data memory port between the instruction fetch unit (IFU) and the load/store unit (LSU) as the core moves from DPI pmem_read/pmem_write to a handshaked bus.
- Accepts one request at a time from either side and issues it on the memory port.
- Returns the memory response to the requester that issued it.
- LSU has priority; a starvation limit guarantees IFU forward progress. A timeout converts a hung memory access into an error response.

---
 rtl/mem_port_arbiter_if.sv | 57 +++++
 rtl/mem_port_arbiter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the IFU, the LSU, the data memory port and the arbiter.
// master: arbiter side; slave: requesters plus memory.
interface mem_port_arbiter_if;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_req_addr;
  logic        ifu_resp_valid;
  logic [31:0] ifu_resp_data;
  logic        ifu_resp_err;

  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic [31:0] lsu_req_addr;
  logic        lsu_req_wen;
  logic [31:0] lsu_req_wdata;
  logic [7:0]  lsu_req_wmask;
  logic        lsu_resp_valid;
  logic [31:0] lsu_resp_data;
  logic        lsu_resp_err;

  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_wen;
  logic [31:0] mem_req_wdata;
  logic [7:0]  mem_req_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;

  modport master (
    input  ifu_req_valid, ifu_req_addr,
    output ifu_req_ready,
    output ifu_resp_valid, ifu_resp_data, ifu_resp_err,
    input  lsu_req_valid, lsu_req_addr, lsu_req_wen,
    input  lsu_req_wdata, lsu_req_wmask,
    output lsu_req_ready,
    output lsu_resp_valid, lsu_resp_data, lsu_resp_err,
    output mem_req_valid, mem_req_addr, mem_req_wen,
    output mem_req_wdata, mem_req_wmask,
    input  mem_req_ready,
    input  mem_resp_valid, mem_resp_data
  );

  modport slave (
    output ifu_req_valid, ifu_req_addr,
    input  ifu_req_ready,
    input  ifu_resp_valid, ifu_resp_data, ifu_resp_err,
    output lsu_req_valid, lsu_req_addr, lsu_req_wen,
    output lsu_req_wdata, lsu_req_wmask,
    input  lsu_req_ready,
    input  lsu_resp_valid, lsu_resp_data, lsu_resp_err,
    input  mem_req_valid, mem_req_addr, mem_req_wen,
    input  mem_req_wdata, mem_req_wmask,
    output mem_req_ready,
    output mem_resp_valid, mem_resp_data
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between IFU and LSU, one transaction at a time.
// Ports: clk, rst (sync, active-low), bus (arbiter side), busy (not IDLE).
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 2,
  parameter int TIMEOUT      = 255,
  parameter int CNT_W        = 8
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.master bus,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } state_t;

  localparam int SW = $clog2(STARVE_LIMIT + 2);
  localparam logic [SW-1:0]    S_LIM = SW'(STARVE_LIMIT);
  localparam logic [SW-1:0]    S_MAX = '1;
  localparam logic [CNT_W-1:0] T_LIM = CNT_W'(TIMEOUT);

  state_t            state;
  logic              owner;
  logic [SW-1:0]     starve_cnt;
  logic [CNT_W-1:0]  tcnt;
  logic [31:0]       a_addr;
  logic              a_wen;
  logic [31:0]       a_wdata;
  logic [7:0]        a_wmask;
  logic [31:0]       r_data;
  logic              r_err;
  logic              req_v;
  logic              ifu_rv;
  logic              lsu_rv;
  logic              busy_q;

  logic              starved;
  logic              lsu_win;
  logic              ifu_win;
  logic              idle_ok;
  logic              ifu_hs;
  logic              lsu_hs;
  logic [CNT_W-1:0]  tcnt_inc;
  logic              t_hit;

  // LSU wins ties until IFU has been passed over STARVE_LIMIT times.
  assign starved = starve_cnt >= S_LIM;
  assign lsu_win = bus.lsu_req_valid &
                   (~bus.ifu_req_valid | ~starved);
  assign ifu_win = bus.ifu_req_valid & ~lsu_win;

  // No grant while reset is held, so nothing is accepted into reset.
  assign idle_ok = (state == IDLE) & rst;

  assign bus.ifu_req_ready = idle_ok & ifu_win;
  assign bus.lsu_req_ready = idle_ok & lsu_win;

  assign ifu_hs = bus.ifu_req_valid & bus.ifu_req_ready;
  assign lsu_hs = bus.lsu_req_valid & bus.lsu_req_ready;

  // Timeout fires on the cycle the count would reach TIMEOUT.
  assign tcnt_inc = tcnt + 1'b1;
  assign t_hit    = tcnt_inc == T_LIM;

  assign bus.mem_req_valid = req_v;
  assign bus.mem_req_addr  = a_addr;
  assign bus.mem_req_wen   = a_wen;
  assign bus.mem_req_wdata = a_wdata;
  assign bus.mem_req_wmask = a_wmask;

  assign bus.ifu_resp_valid = ifu_rv;
  assign bus.ifu_resp_data  = r_data;
  assign bus.ifu_resp_err   = r_err;
  assign bus.lsu_resp_valid = lsu_rv;
  assign bus.lsu_resp_data  = r_data;
  assign bus.lsu_resp_err   = r_err;

  assign busy = busy_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      starve_cnt <= '0;
      tcnt       <= '0;
      a_addr     <= '0;
      a_wen      <= 1'b0;
      a_wdata    <= '0;
      a_wmask    <= '0;
      r_data     <= '0;
      r_err      <= 1'b0;
      req_v      <= 1'b0;
      ifu_rv     <= 1'b0;
      lsu_rv     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      ifu_rv <= 1'b0;
      lsu_rv <= 1'b0;
      unique case (state)
        IDLE: begin
          if (lsu_hs) begin
            a_addr  <= bus.lsu_req_addr;
            a_wen   <= bus.lsu_req_wen;
            a_wdata <= bus.lsu_req_wdata;
            a_wmask <= bus.lsu_req_wmask;
            owner   <= 1'b1;
            tcnt    <= '0;
            req_v   <= 1'b1;
            busy_q  <= 1'b1;
            state   <= REQ;
            if (bus.ifu_req_valid && starve_cnt != S_MAX)
              starve_cnt <= starve_cnt + 1'b1;
          end else if (ifu_hs) begin
            a_addr     <= bus.ifu_req_addr;
            a_wen      <= 1'b0;
            a_wdata    <= '0;
            a_wmask    <= '0;
            owner      <= 1'b0;
            starve_cnt <= '0;
            tcnt       <= '0;
            req_v      <= 1'b1;
            busy_q     <= 1'b1;
            state      <= REQ;
          end
        end
        REQ: begin
          if (t_hit) begin
            r_data <= '0;
            r_err  <= 1'b1;
            req_v  <= 1'b0;
            ifu_rv <= ~owner;
            lsu_rv <= owner;
            state  <= RESP;
          end else begin
            tcnt <= tcnt_inc;
            if (bus.mem_req_ready) begin
              req_v <= 1'b0;
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          // A real response in the timeout cycle still counts.
          if (bus.mem_resp_valid) begin
            r_data <= a_wen ? 32'h0 : bus.mem_resp_data;
            r_err  <= 1'b0;
            ifu_rv <= ~owner;
            lsu_rv <= owner;
            state  <= RESP;
          end else if (t_hit) begin
            r_data <= '0;
            r_err  <= 1'b1;
            ifu_rv <= ~owner;
            lsu_rv <= owner;
            state  <= RESP;
          end else begin
            tcnt <= tcnt_inc;
          end
        end
        RESP: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          req_v  <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
